div_iter: RTL

Parametrised multi-cycle iterative divider. It is the successor to the fixed 32-bit divider that serves the EX stage's DIV/DIVU path. It computes quotient and remainder one bit per cycle with restoring division, for signed or unsigned operands of configurable width. It adds annul, divide-by-zero flagging and a busy indication. EX drives it with a start/ready handshake and writes {remainder, quotient} to {HI, LO}.

---
 rtl/div_iter_pkg.sv | 35 +++
 rtl/div_iter_if.sv | 37 +++
 rtl/div_iter_sign_fix.sv | 28 ++
 rtl/div_iter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// -----------------------------------------------------------------------------
// div_iter_pkg
// Shared definitions for the iterative divider: FSM state encodings, the
// start/stop and result-ready levels used on the EX handshake, the
// signed/unsigned operand select values and a small sign helper.
// No ports (package).
// -----------------------------------------------------------------------------
package div_iter_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivSigned         = 1'b1;
    localparam logic DivUnsigned       = 1'b0;

    // An operand is treated as negative only in signed mode with its MSB set.
    function automatic logic operand_negative(input logic sign_sel, input logic msb);
        logic neg;
        case (sign_sel)
            DivSigned:   neg = msb;
            DivUnsigned: neg = 1'b0;
            default:     neg = 1'b0;
        endcase
        return neg;
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// -----------------------------------------------------------------------------
// div_iter_if
// Request/response bundle between the EX stage (master) and the divider
// (slave).
//   signed_div_i  : 1 = signed operands
//   opdata1_i     : dividend
//   opdata2_i     : divisor
//   start_i       : request, held until ready_o is seen
//   annul_i       : cancel current/pending operation
//   result_o      : {remainder, quotient}
//   ready_o       : result valid
//   div_by_zero_o : divisor was zero (valid with ready_o)
//   busy_o        : divider is computing
// -----------------------------------------------------------------------------
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   div_by_zero_o;
    logic                   busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, div_by_zero_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, div_by_zero_o, busy_o
    );
endinterface

// File: rtl/div_iter_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
// Combinational conditional two's-complement. Used on the way in to turn a
// negative operand into its magnitude, and on the way out to apply the sign
// to quotient or remainder.
//   value  : input word
//   negate : 1 = output is -value, 0 = output is value
//   fixed  : result
// -----------------------------------------------------------------------------
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] fixed
);

    // Conditional negation; the most negative value maps onto itself, which is
    // exactly the unsigned magnitude we need on input and the wrap on output.
    always_comb begin
        if (negate) begin
            fixed = (~value) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            fixed = value;
        end
    end

endmodule

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Multi-cycle restoring divider, one quotient bit per clock, signed or
// unsigned operands of WIDTH bits. Result is {remainder, quotient}.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : div_iter_if slave port (operands, start/annul, result/ready/flags)
// Latency from the edge that accepts start_i: ready_o after edge WIDTH+2, or
// after edge 2 when the divisor is zero.
// -----------------------------------------------------------------------------
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    div_iter_if.slave   bus
);

    div_state_e             state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [2*WIDTH:0]       work_r, work_s;
    logic [WIDTH-1:0]       divisor_r, divisor_s;
    logic                   dvd_neg_r, dvd_neg_s;
    logic                   dvs_neg_r, dvs_neg_s;
    logic [2*WIDTH-1:0]     result_r, result_s;
    logic                   ready_r, ready_s;
    logic                   dbz_r, dbz_s;
    logic                   busy_r, busy_s;

    logic                   in_dvd_neg_s;
    logic                   in_dvs_neg_s;
    logic [WIDTH-1:0]       dvd_mag_s;
    logic [WIDTH-1:0]       dvs_mag_s;
    logic [WIDTH-1:0]       quo_fix_s;
    logic [WIDTH-1:0]       rem_fix_s;
    logic [WIDTH+1:0]       upper_s;
    logic [WIDTH+1:0]       diff_s;

    assign in_dvd_neg_s = operand_negative(bus.signed_div_i, bus.opdata1_i[WIDTH-1]);
    assign in_dvs_neg_s = operand_negative(bus.signed_div_i, bus.opdata2_i[WIDTH-1]);

    div_sign_fix #(.WIDTH(WIDTH)) u_dvd_mag (
        .value  (bus.opdata1_i),
        .negate (in_dvd_neg_s),
        .fixed  (dvd_mag_s)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_dvs_mag (
        .value  (bus.opdata2_i),
        .negate (in_dvs_neg_s),
        .fixed  (dvs_mag_s)
    );

    // Quotient is negative when operand signs differ.
    div_sign_fix #(.WIDTH(WIDTH)) u_quo_fix (
        .value  (work_r[WIDTH-1:0]),
        .negate (dvd_neg_r ^ dvs_neg_r),
        .fixed  (quo_fix_s)
    );

    // Remainder follows the dividend sign.
    div_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
        .value  (work_r[2*WIDTH-1:WIDTH]),
        .negate (dvd_neg_r),
        .fixed  (rem_fix_s)
    );

    // Trial subtraction on the partial remainder as it will look after the
    // left shift. One extra bit above the shifted window carries the sign, so
    // the top work bit (always zero going in) simply feeds that sign position.
    assign upper_s = work_r[2*WIDTH:WIDTH-1];
    assign diff_s  = upper_s - {2'b00, divisor_r};

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        work_s    = work_r;
        divisor_s = divisor_r;
        dvd_neg_s = dvd_neg_r;
        dvs_neg_s = dvs_neg_r;
        result_s  = result_r;
        ready_s   = DivResultNotReady;
        dbz_s     = 1'b0;
        busy_s    = 1'b0;

        case (state_r)
            DivFree: begin
                // annul has priority: a flushed instruction is never accepted
                if ((bus.start_i == DivStart) && (bus.annul_i == 1'b0)) begin
                    work_s    = {{(WIDTH+1){1'b0}}, dvd_mag_s};
                    divisor_s = dvs_mag_s;
                    dvd_neg_s = in_dvd_neg_s;
                    dvs_neg_s = in_dvs_neg_s;
                    cnt_s     = {CNT_W{1'b0}};
                    busy_s    = 1'b1;
                    if (bus.opdata2_i == {WIDTH{1'b0}}) begin
                        state_s = DivByZero;
                    end else begin
                        state_s = DivOn;
                    end
                end else begin
                    state_s = DivFree;
                end
            end

            DivByZero: begin
                if (bus.annul_i == 1'b1) begin
                    state_s = DivFree;
                end else begin
                    state_s  = DivEnd;
                    result_s = {(2*WIDTH){1'b0}};
                    ready_s  = DivResultReady;
                    dbz_s    = 1'b1;
                end
            end

            DivOn: begin
                if (bus.annul_i == 1'b1) begin
                    state_s = DivFree;
                end else if (cnt_r == CNT_W'(WIDTH)) begin
                    state_s  = DivEnd;
                    result_s = {rem_fix_s, quo_fix_s};
                    ready_s  = DivResultReady;
                end else begin
                    busy_s = 1'b1;
                    cnt_s  = cnt_r + CNT_W'(1);
                    if (diff_s[WIDTH+1] == 1'b0) begin
                        work_s = {diff_s[WIDTH:0], work_r[WIDTH-2:0], 1'b1};
                    end else begin
                        work_s = {work_r[2*WIDTH-1:0], 1'b0};
                    end
                end
            end

            DivEnd: begin
                if (bus.annul_i == 1'b1) begin
                    state_s = DivFree;
                end else if (bus.start_i == DivStop) begin
                    state_s = DivFree;
                end else begin
                    state_s = DivEnd;
                    ready_s = DivResultReady;
                    dbz_s   = dbz_r;
                end
            end

            default: begin
                state_s = DivFree;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= DivFree;
            cnt_r     <= {CNT_W{1'b0}};
            work_r    <= {(2*WIDTH+1){1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            dvd_neg_r <= 1'b0;
            dvs_neg_r <= 1'b0;
            result_r  <= {(2*WIDTH){1'b0}};
            ready_r   <= DivResultNotReady;
            dbz_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            work_r    <= work_s;
            divisor_r <= divisor_s;
            dvd_neg_r <= dvd_neg_s;
            dvs_neg_r <= dvs_neg_s;
            result_r  <= result_s;
            ready_r   <= ready_s;
            dbz_r     <= dbz_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.result_o      = result_r;
    assign bus.ready_o       = ready_r;
    assign bus.div_by_zero_o = dbz_r;
    assign bus.busy_o        = busy_r;

endmodule
